// File: rtl/id_stage_pipe.sv
// Instruction decode stage: register-file read with write-back bypass, immediate extension, ID/EX register.
// Latency: 1 cycle from accept to out_valid; 1 instruction/cycle when no hazard and out_ready=1.
// Backpressure: holds ID/EX while !out_ready; load-use hazard drops in_ready for exactly one bubble.
//
// Ports:
//   clock, reset               - rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready          - handshake from IF; instruction + sign_ext_in/write_reg_in/mem_read_in
//   wb_we/wb_rd/wb_data        - write-back port into the register file (also bypassed into reads)
//   flush                      - kills ID/EX contents and the incoming instruction
//   out_valid/out_ready        - handshake to EX; data1/data2, rs1_out/rs2_out/rd_out, imm_out, control bits
//   stall_count                - saturating count of hazard bubbles inserted
module id_stage_pipe #(
    parameter int DATA_W      = 8,
    parameter int REG_ADDR_W  = 3,
    parameter int INSTR_W     = 16,   // must be >= 3*REG_ADDR_W + IMM_W
    parameter int IMM_W       = 4,    // must be <= DATA_W
    parameter int ZERO_REG    = 1,
    parameter int STALL_CNT_W = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_W-1:0]     instruction,
    input  logic                   sign_ext_in,
    input  logic                   write_reg_in,
    input  logic                   mem_read_in,
    input  logic                   wb_we,
    input  logic [REG_ADDR_W-1:0]  wb_rd,
    input  logic [DATA_W-1:0]      wb_data,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      data1,
    output logic [DATA_W-1:0]      data2,
    output logic [REG_ADDR_W-1:0]  rs1_out,
    output logic [REG_ADDR_W-1:0]  rs2_out,
    output logic [REG_ADDR_W-1:0]  rd_out,
    output logic [DATA_W-1:0]      imm_out,
    output logic                   sign_ext_out,
    output logic                   write_reg_out,
    output logic                   mem_read_out,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam int RAW      = REG_ADDR_W;
    localparam int NUM_REGS = 2 ** REG_ADDR_W;

    logic [RAW-1:0]    rs1;
    logic [RAW-1:0]    rs2;
    logic [RAW-1:0]    rd;
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] rf_q [NUM_REGS];
    logic [DATA_W-1:0] rd1_val;
    logic [DATA_W-1:0] rd2_val;
    logic [DATA_W-1:0] imm_ext;
    logic              hazard;
    logic              adv;
    logic              unused_instr_bits;

    assign rs1 = instruction[RAW-1:0];
    assign rs2 = instruction[2*RAW-1:RAW];
    assign rd  = instruction[3*RAW-1:2*RAW];
    assign imm = instruction[INSTR_W-1 -: IMM_W];

    // Gap bits between rd and imm carry no meaning for this stage.
    assign unused_instr_bits = ^instruction;

    function automatic logic forced_zero(input logic [RAW-1:0] idx);
        return (ZERO_REG != 0) && (idx == '0);
    endfunction

    // Register file; writes to a forced-zero register are dropped.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_we && !forced_zero(wb_rd)) begin
            rf_q[wb_rd] <= wb_data;
        end
    end

    // Reads see a same-cycle write-back so the captured operand is never one write behind.
    always_comb begin
        rd1_val = rf_q[rs1];
        if (forced_zero(rs1)) begin
            rd1_val = '0;
        end else if (wb_we && (wb_rd == rs1)) begin
            rd1_val = wb_data;
        end
    end

    always_comb begin
        rd2_val = rf_q[rs2];
        if (forced_zero(rs2)) begin
            rd2_val = '0;
        end else if (wb_we && (wb_rd == rs2)) begin
            rd2_val = wb_data;
        end
    end

    // Fill every bit with the extension value, then overlay the raw field; works for IMM_W == DATA_W too.
    always_comb begin
        imm_ext            = {DATA_W{sign_ext_in & imm[IMM_W-1]}};
        imm_ext[IMM_W-1:0] = imm;
    end

    // A load in ID/EX whose destination feeds the incoming instruction cannot be bypassed in time.
    assign hazard = out_valid && mem_read_out && write_reg_out && in_valid &&
                    ((rd_out == rs1) || (rd_out == rs2)) && !forced_zero(rd_out);
    assign adv      = !out_valid || out_ready;
    assign in_ready = flush || (adv && !hazard);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid     <= 1'b0;
            data1         <= '0;
            data2         <= '0;
            rs1_out       <= '0;
            rs2_out       <= '0;
            rd_out        <= '0;
            imm_out       <= '0;
            sign_ext_out  <= 1'b0;
            write_reg_out <= 1'b0;
            mem_read_out  <= 1'b0;
            stall_count   <= '0;
        end else if (flush) begin
            out_valid     <= 1'b0;
            write_reg_out <= 1'b0;
            mem_read_out  <= 1'b0;
        end else if (adv && hazard) begin
            out_valid     <= 1'b0;
            write_reg_out <= 1'b0;
            mem_read_out  <= 1'b0;
            if (stall_count != '1) begin
                stall_count <= stall_count + 1'b1;
            end
        end else if (adv && in_valid) begin
            out_valid     <= 1'b1;
            data1         <= rd1_val;
            data2         <= rd2_val;
            rs1_out       <= rs1;
            rs2_out       <= rs2;
            rd_out        <= rd;
            imm_out       <= imm_ext;
            sign_ext_out  <= sign_ext_in;
            write_reg_out <= write_reg_in;
            mem_read_out  <= mem_read_in;
        end else if (adv) begin
            out_valid     <= 1'b0;
            write_reg_out <= 1'b0;
            mem_read_out  <= 1'b0;
        end else begin
            // Holding for EX: keep operands current with any write-back to their source registers.
            if (wb_we && (wb_rd == rs1_out) && !forced_zero(rs1_out)) begin
                data1 <= wb_data;
            end
            if (wb_we && (wb_rd == rs2_out) && !forced_zero(rs2_out)) begin
                data2 <= wb_data;
            end
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Testbench for id_stage_pipe: directed vectors, literal expectations, and a per-cycle reference model.
// Latency: outputs compared on every falling edge against the model's view of the ID/EX register.
// Backpressure: exercises out_ready holds, load-use bubbles, flush and stall-count saturation.
module tb_id_stage_pipe;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instruction;
    logic        sign_ext_in;
    logic        write_reg_in;
    logic        mem_read_in;
    logic        wb_we;
    logic [2:0]  wb_rd;
    logic [7:0]  wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  data1;
    logic [7:0]  data2;
    logic [2:0]  rs1_out;
    logic [2:0]  rs2_out;
    logic [2:0]  rd_out;
    logic [7:0]  imm_out;
    logic        sign_ext_out;
    logic        write_reg_out;
    logic        mem_read_out;
    logic [7:0]  stall_count;

    int checks = 0;
    int errors = 0;

    id_stage_pipe dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instruction  (instruction),
        .sign_ext_in  (sign_ext_in),
        .write_reg_in (write_reg_in),
        .mem_read_in  (mem_read_in),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .data1        (data1),
        .data2        (data2),
        .rs1_out      (rs1_out),
        .rs2_out      (rs2_out),
        .rd_out       (rd_out),
        .imm_out      (imm_out),
        .sign_ext_out (sign_ext_out),
        .write_reg_out(write_reg_out),
        .mem_read_out (mem_read_out),
        .stall_count  (stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mk(input int rd, input int rs2, input int rs1, input int imm);
        logic [15:0] w;
        w        = '0;
        w[2:0]   = 3'(rs1);
        w[5:3]   = 3'(rs2);
        w[8:6]   = 3'(rd);
        w[15:12] = 4'(imm);
        return w;
    endfunction

    // Reference model: architectural register values plus the instruction sitting in ID/EX.
    // Operands of a valid ID/EX entry always equal the current architectural value of their sources.
    int m_rf [8];
    int m_valid, m_rs1, m_rs2, m_rd, m_imm, m_sx, m_wr, m_mr, m_stall;

    function automatic int reg_val(input int idx);
        return (idx == 0) ? 0 : m_rf[idx];
    endfunction

    function automatic int model_hazard();
        int f1, f2;
        f1 = int'(instruction[2:0]);
        f2 = int'(instruction[5:3]);
        return (m_valid != 0 && m_mr != 0 && m_wr != 0 && in_valid === 1'b1 && m_rd != 0 &&
                (m_rd == f1 || m_rd == f2)) ? 1 : 0;
    endfunction

    function automatic int model_in_ready();
        int adv;
        adv = (m_valid == 0 || out_ready === 1'b1) ? 1 : 0;
        return (flush === 1'b1 || (adv != 0 && model_hazard() == 0)) ? 1 : 0;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) m_rf[i] = 0;
            m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_imm = 0;
            m_sx = 0; m_wr = 0; m_mr = 0; m_stall = 0;
        end else begin
            int adv, hz;
            adv = (m_valid == 0 || out_ready) ? 1 : 0;
            hz  = model_hazard();
            if (flush) begin
                m_valid = 0; m_wr = 0; m_mr = 0;
            end else if (adv != 0 && hz != 0) begin
                m_valid = 0; m_wr = 0; m_mr = 0;
                if (m_stall < 255) m_stall = m_stall + 1;
            end else if (adv != 0 && in_valid) begin
                m_valid = 1;
                m_rs1 = int'(instruction[2:0]);
                m_rs2 = int'(instruction[5:3]);
                m_rd  = int'(instruction[8:6]);
                m_imm = int'(instruction[15:12]);
                m_sx  = int'(sign_ext_in);
                m_wr  = int'(write_reg_in);
                m_mr  = int'(mem_read_in);
            end else if (adv != 0) begin
                m_valid = 0; m_wr = 0; m_mr = 0;
            end
            if (wb_we && wb_rd != 3'd0) m_rf[wb_rd] = int'(wb_data);
        end
    end

    always @(negedge clock) begin
        check("in_ready", 32'(in_ready), 32'(model_in_ready()));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("write_reg_out", 32'(write_reg_out), 32'(m_wr));
        check("mem_read_out", 32'(mem_read_out), 32'(m_mr));
        check("stall_count", 32'(stall_count), 32'(m_stall));
        if (m_valid != 0) begin
            int e_imm;
            e_imm = (m_sx != 0 && m_imm >= 8) ? (m_imm - 16 + 256) : m_imm;
            check("rs1_out", 32'(rs1_out), 32'(m_rs1));
            check("rs2_out", 32'(rs2_out), 32'(m_rs2));
            check("rd_out", 32'(rd_out), 32'(m_rd));
            check("data1", 32'(data1), 32'(reg_val(m_rs1)));
            check("data2", 32'(data2), 32'(reg_val(m_rs2)));
            check("imm_out", 32'(imm_out), 32'(e_imm));
            check("sign_ext_out", 32'(sign_ext_out), 32'(m_sx));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; instruction = '0; sign_ext_in = 1'b0;
        write_reg_in = 1'b0; mem_read_in = 1'b0; wb_we = 1'b0; wb_rd = '0;
        wb_data = '0; flush = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        check("rst out_valid", 32'(out_valid), 32'h0);
        check("rst data1", 32'(data1), 32'h0);
        check("rst data2", 32'(data2), 32'h0);
        check("rst imm_out", 32'(imm_out), 32'h0);
        check("rst rd_out", 32'(rd_out), 32'h0);
        check("rst stall_count", 32'(stall_count), 32'h0);
        reset = 1'b1;

        // r3 = 5A
        wb_we = 1'b1; wb_rd = 3'd3; wb_data = 8'h5A;
        tick();
        // Accept rs1=3, rs2=0, sign-extended imm 1010; r0 write is dropped.
        in_valid = 1'b1; instruction = mk(1, 0, 3, 4'b1010); sign_ext_in = 1'b1;
        write_reg_in = 1'b1; wb_rd = 3'd0; wb_data = 8'hFF;
        #1 check("accept in_ready", 32'(in_ready), 32'h1);
        tick();
        check("t1 out_valid", 32'(out_valid), 32'h1);
        check("t1 data1", 32'(data1), 32'h5A);
        check("t1 data2 r0", 32'(data2), 32'h00);
        check("t1 imm sext", 32'(imm_out), 32'hFA);
        check("t1 rd_out", 32'(rd_out), 32'h1);

        // Same-cycle bypass into rs2=2, zero-extended immediate.
        instruction = mk(2, 2, 0, 4'b1010); sign_ext_in = 1'b0;
        wb_rd = 3'd2; wb_data = 8'hC3;
        tick();
        check("byp data2", 32'(data2), 32'hC3);
        check("byp imm zext", 32'(imm_out), 32'h0A);
        in_valid = 1'b0; wb_we = 1'b0;
        tick();
        check("idle out_valid", 32'(out_valid), 32'h0);

        // Load-use: load rd=4 then consumer with rs1=4.
        in_valid = 1'b1; instruction = mk(4, 0, 0, 0); mem_read_in = 1'b1; write_reg_in = 1'b1;
        tick();
        instruction = mk(5, 0, 4, 0); mem_read_in = 1'b0;
        #1 check("hazard in_ready", 32'(in_ready), 32'h0);
        tick();
        check("bubble out_valid", 32'(out_valid), 32'h0);
        check("bubble stall", 32'(stall_count), 32'h1);
        wb_we = 1'b1; wb_rd = 3'd4; wb_data = 8'h77;
        #1 check("after bubble in_ready", 32'(in_ready), 32'h1);
        tick();
        check("lu out_valid", 32'(out_valid), 32'h1);
        check("lu rs1_out", 32'(rs1_out), 32'h4);
        check("lu data1", 32'(data1), 32'h77);
        wb_we = 1'b0;

        // Back-pressure with write-back to a held source register.
        instruction = mk(6, 3, 5, 0); write_reg_in = 1'b0;
        tick();
        out_ready = 1'b0; instruction = mk(1, 1, 1, 0);
        wb_we = 1'b1; wb_rd = 3'd5; wb_data = 8'h11;
        #1 check("hold in_ready 0", 32'(in_ready), 32'h0);
        tick();
        wb_we = 1'b0;
        check("hold in_ready 1", 32'(in_ready), 32'h0);
        tick();
        check("hold in_ready 2", 32'(in_ready), 32'h0);
        tick();
        check("hold data1", 32'(data1), 32'h11);
        check("hold data2", 32'(data2), 32'h5A);
        check("hold rs1_out", 32'(rs1_out), 32'h5);
        out_ready = 1'b1;
        #1 check("release in_ready", 32'(in_ready), 32'h1);
        tick();
        check("release rs1_out", 32'(rs1_out), 32'h1);

        // Flush with valid ID/EX and a valid incoming instruction.
        instruction = mk(7, 7, 7, 5); flush = 1'b1;
        #1 check("flush in_ready", 32'(in_ready), 32'h1);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush out_valid", 32'(out_valid), 32'h0);
        check("flush stall", 32'(stall_count), 32'h1);
        tick();
        check("flush dropped", 32'(out_valid), 32'h0);

        // Back-to-back self-dependent loads: one bubble every two cycles until saturation.
        in_valid = 1'b1; instruction = mk(4, 0, 4, 0); mem_read_in = 1'b1; write_reg_in = 1'b1;
        for (int i = 0; i < 520; i++) tick();
        check("sat stall", 32'(stall_count), 32'hFF);
        tick();
        tick();
        check("sat hold", 32'(stall_count), 32'hFF);

        // Reset in mid-operation clears immediately.
        reset = 1'b0;
        #1;
        check("mid rst out_valid", 32'(out_valid), 32'h0);
        check("mid rst stall", 32'(stall_count), 32'h0);
        check("mid rst in_ready", 32'(in_ready), 32'h1);
        tick();
        reset = 1'b1; in_valid = 1'b0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
